sat_comb: RTL
=============

# sat_comb

Streaming saturating differentiator (comb stage): each accepted signed sample x[n] produces y[n] = sat(x[n] − x[n−DELAY]). It undoes what a saturating adder-based accumulator builds up, and sits downstream of it in the datapath. Valid/ready handshake on both sides, one-cycle registered output, and a saturation event counter.

## Interface
- DATA_WIDTH, 16, sample width, two's complement
- DELAY, 1, differential delay in accepted samples, ≥1
- CNT_WIDTH, 16, width of saturation event counter
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  block can accept input
- s_data_i  in  DATA_WIDTH  signed input sample x[n]
- clear_i  in  1  zero the history (delay line) this cycle
- m_valid_o  out  1  output sample valid
- m_ready_i  in  1  downstream accepts output
- m_data_o  out  DATA_WIDTH  signed result y[n]
- sat_o  out  1  qualifies m_data_o: result was clamped
- sat_cnt_o  out  CNT_WIDTH  number of clamped results since reset; sticks at all-ones

## Operation
- Input accept = s_valid_i & s_ready_o; output transfer = m_valid_o & m_ready_i.
- s_ready_o = ~m_valid_o | m_ready_i (combinational; single output register, full throughput).
- History: DELAY-entry shift register of past accepted inputs. It shifts only on input accept: new x enters entry 0; entry DELAY−1 is the subtrahend. It is all-zero after reset.
- Arithmetic: d = sign-extended x − sign-extended h, computed at DATA_WIDTH+1 bits.
  - If d > MAX (2^(W−1)−1), the result is MAX.
  - If d < MIN (−2^(W−1)), the result is MIN.
  - Otherwise the result is d[W−1:0].
  - sat_o = 1 iff the result was clamped.
- On input accept: the output register loads the result and sat_o, and m_valid_o=1.
- Output transfer with no accept in the same cycle: m_valid_o=0. m_data_o and sat_o hold their last value.
- sat_cnt_o increments on each accept with a clamp; it saturates at 2^CNT_WIDTH−1 and never wraps.
- clear_i:
  - It zeroes all history entries. It does not affect the output register or sat_cnt_o.
  - If clear_i coincides with an accept, the clear is applied first. The accepted sample is differenced against 0, then written to entry 0; all other entries are 0.
- Reset (any cycle, including mid-stall) sets: m_valid_o=0, m_data_o=0, sat_o=0, sat_cnt_o=0, history all 0. Any pending output is dropped.

## Timing
- Latency: accept at edge k; result visible on m_data_o / m_valid_o after edge k, i.e. one cycle.
- Throughput: one sample per cycle while m_ready_i=1.
- Stall: while m_valid_o=1 and m_ready_i=0, s_ready_o=0. Output, history and counter are frozen.
- Simultaneous output transfer and input accept: the new result replaces the old one and m_valid_o stays 1.
- The s_valid_i→s_ready_o path has no combinational dependency; m_ready_i→s_ready_o is combinational.

## Structure
- Shared package sat_pkg:
  - localparams for MAX/MIN derived from DATA_WIDTH;
  - function sat_sub(a, b) returning {sat_flag, result};
  - matching sat_add so the accumulator side reuses the same clamp rules.
- Sub-module sample_delay (parameters DATA_WIDTH, DELAY; ports clk_i, rst_i, shift_en, clear, din, dout) implements the history line.
- Top module holds the output register, the handshake logic and the counter.

## Test plan
- Reset, DELAY=1, m_ready_i=1; inputs 100, 300, 250 → outputs 100, 200, −50; sat_o=0; sat_cnt_o=0.
- DELAY=1; inputs 32767 then −32768 → second output −32768 with sat_o=1 (true value −65535); sat_cnt_o=1.
- DELAY=1; inputs −32768 then 32767 → second output 32767 with sat_o=1; sat_cnt_o increments.
- Backpressure: output valid with m_ready_i=0 for 3 cycles and s_valid_i=1 → s_ready_o=0, m_data_o held, no sample consumed. Release m_ready_i → the queued input is accepted in the same cycle and its result appears the next cycle.
- clear_i asserted with an accept of 500 after history 400 → output 500; next input 700 → output 200.
- DELAY=4; ramp inputs 10, 20, 30, … → outputs 10, 20, 30, 40, then constant 40. Reset asserted mid-stream → m_valid_o=0 next cycle, and the first post-reset output equals the raw input.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared saturation helpers for the accumulator and the comb datapath.
// Both sides use the same clamp rules, so a sample width change is made here once.
package sat_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    localparam sample_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic    sat;
        sample_t data;
    } sat_res_t;

    // A (W+1)-bit value is in range exactly when its top two bits agree.
    function automatic sat_res_t clamp_wide(input logic [DATA_W:0] d);
        sat_res_t r;
        if (d[DATA_W] == d[DATA_W-1]) begin
            r.sat  = 1'b0;
            r.data = d[DATA_W-1:0];
        end else if (d[DATA_W] == 1'b0) begin
            r.sat  = 1'b1;
            r.data = SAT_MAX;
        end else begin
            r.sat  = 1'b1;
            r.data = SAT_MIN;
        end
        return r;
    endfunction

    function automatic sat_res_t sat_sub(input sample_t a, input sample_t b);
        logic [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return clamp_wide(d);
    endfunction

    function automatic sat_res_t sat_add(input sample_t a, input sample_t b);
        logic [DATA_W:0] d;
        d = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return clamp_wide(d);
    endfunction

endpackage

// File: rtl/sample_delay.sv
// History line of past accepted samples; dout is the sample DELAY accepts ago.
module sample_delay #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] line_r [DELAY];

    // Shift on accept; clear zeroes everything except the sample entering this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DELAY; i++) begin
                line_r[i] <= '0;
            end
        end else if (shift_en) begin
            line_r[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                line_r[i] <= clear ? '0 : line_r[i-1];
            end
        end else if (clear) begin
            for (int i = 0; i < DELAY; i++) begin
                line_r[i] <= '0;
            end
        end
    end

    assign dout = line_r[DELAY-1];

endmodule

// File: rtl/sat_comb.sv
// Saturating comb stage y[n] = sat(x[n] - x[n-DELAY]) with valid/ready on both sides.
// DATA_WIDTH must match sat_pkg::DATA_W, which fixes the clamp arithmetic width.
module sat_comb
    import sat_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int DELAY      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  clear_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  sat_o,
    output logic [CNT_WIDTH-1:0]  sat_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_TOP = {CNT_WIDTH{1'b1}};

    logic                  accept_s;
    logic [DATA_WIDTH-1:0] hist_raw_s;
    sample_t               hist_s;
    sat_res_t              res_s;

    assign s_ready_o = ~m_valid_o | m_ready_i;
    assign accept_s  = s_valid_i & s_ready_o;

    sample_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DELAY      (DELAY)
    ) u_hist (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .shift_en (accept_s),
        .clear    (clear_i),
        .din      (s_data_i),
        .dout     (hist_raw_s)
    );

    // A clear in the accept cycle makes the new sample difference against zero.
    always_comb begin
        hist_s = '0;
        if (clear_i) begin
            hist_s = '0;
        end else begin
            hist_s = hist_raw_s;
        end
        res_s = sat_sub(s_data_i, hist_s);
    end

    // Single output register: reloads on accept, drops valid on a bare transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            sat_o     <= 1'b0;
        end else if (accept_s) begin
            m_valid_o <= 1'b1;
            m_data_o  <= res_s.data;
            sat_o     <= res_s.sat;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

    // Clamp event counter, sticky at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_cnt_o <= '0;
        end else if (accept_s && res_s.sat && (sat_cnt_o != CNT_TOP)) begin
            sat_cnt_o <= sat_cnt_o + CNT_ONE;
        end
    end

endmodule
